// File: rtl/icache_pkg.sv
// Shared types and sizing for the direct-mapped instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_pkg;

    typedef enum logic {
        COMPARE  = 1'b0,
        ALLOCATE = 1'b1
    } state_t;

    localparam int LINE_W   = 128;
    localparam int WORDS    = 4;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = $clog2(WORDS);

    // Tag width left over once the word offset and the line index are removed.
    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w - OFFSET_W;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Core-side fetch port plus memory-side line refill port of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: proc_stall holds the core; mem_read/mem_ready handshake paces the refill.
interface icache_if
    import icache_pkg::*;
#(
    parameter int ADDR_W = 30
);
    logic                proc_read;
    logic [ADDR_W-1:0]   proc_addr;
    logic [WORD_W-1:0]   proc_rdata;
    logic                proc_stall;
    logic                mem_read;
    logic [ADDR_W-3:0]   mem_addr;
    logic [LINE_W-1:0]   mem_rdata;
    logic                mem_ready;

    // Cache side.
    modport slave (
        input  proc_read, proc_addr, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_addr
    );

    // Core plus memory side.
    modport master (
        output proc_read, proc_addr, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_addr
    );
endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for every cache line: one write port, one combinational read port.
// Latency: read 0 cycles, write visible the cycle after we.
// Backpressure: none; writes are always accepted, reset clears everything.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 25
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line
);
    localparam int LINES = 1 << INDEX_W;

    logic              valid_arr [LINES];
    logic [TAG_W-1:0]  tag_arr   [LINES];
    logic [LINE_W-1:0] data_arr  [LINES];

    // Clear all lines on reset, otherwise install a refilled line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                valid_arr[i] <= 1'b0;
                tag_arr[i]   <= '0;
                data_arr[i]  <= '0;
            end
        end else if (we) begin
            valid_arr[wr_index] <= 1'b1;
            tag_arr[wr_index]   <= wr_tag;
            data_arr[wr_index]  <= wr_line;
        end
    end

    assign rd_valid = valid_arr[rd_index];
    assign rd_tag   = tag_arr[rd_index];
    assign rd_line  = data_arr[rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: hit compare, word select and refill FSM.
// Latency: hit 0 cycles; miss 1 + k cycles where k is the number of ALLOCATE cycles.
// Backpressure: proc_stall holds the core on a miss; refill waits on mem_ready indefinitely.
module icache_dm
    import icache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int ADDR_W  = 30
)
(
    input  logic      clk,
    input  logic      rst_n,
    icache_if.slave   bus
);
    localparam int TAG_W   = tag_width(ADDR_W, INDEX_W);
    localparam int LADDR_W = ADDR_W - OFFSET_W;

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;

    state_t               state;
    state_t               state_nxt;
    logic [LADDR_W-1:0]   miss_laddr;
    logic [LADDR_W-1:0]   miss_laddr_nxt;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_W-1:0]    rd_line;
    logic                 hit;
    logic                 fill_we;
    logic                 stall;
    logic                 mem_read;
    logic [WORD_W-1:0]    word;

    assign offset = bus.proc_addr[OFFSET_W-1:0];
    assign index  = bus.proc_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign tag    = bus.proc_addr[ADDR_W-1:INDEX_W+OFFSET_W];

    // Refill writes go to the index/tag captured at the miss, not the live address.
    icache_line_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (fill_we),
        .wr_index (miss_laddr[INDEX_W-1:0]),
        .wr_tag   (miss_laddr[LADDR_W-1:INDEX_W]),
        .wr_line  (bus.mem_rdata),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line)
    );

    assign hit  = bus.proc_read & rd_valid & (rd_tag == tag);
    assign word = rd_line[{offset, 5'b0} +: WORD_W];

    // State and captured miss line address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COMPARE;
            miss_laddr <= '0;
        end else begin
            state      <= state_nxt;
            miss_laddr <= miss_laddr_nxt;
        end
    end

    // Next state, refill request and core stall.
    always_comb begin
        state_nxt      = state;
        miss_laddr_nxt = miss_laddr;
        mem_read       = 1'b0;
        stall          = 1'b0;
        fill_we        = 1'b0;
        case (state)
            COMPARE: begin
                if (bus.proc_read && !hit) begin
                    stall          = 1'b1;
                    miss_laddr_nxt = bus.proc_addr[ADDR_W-1:OFFSET_W];
                    state_nxt      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                stall    = 1'b1;
                if (bus.mem_ready) begin
                    fill_we   = 1'b1;
                    state_nxt = COMPARE;
                end
            end
            default: begin
                state_nxt = COMPARE;
            end
        endcase
    end

    // The core is held off and sees zero data for as long as reset is asserted.
    assign bus.proc_stall = rst_n ? stall : 1'b1;
    assign bus.proc_rdata = rst_n ? word : '0;
    assign bus.mem_read   = mem_read;
    assign bus.mem_addr   = miss_laddr;

endmodule
